// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered N-bit ALU with valid/ready handshake and held result/flags.
// Optional iterative shift-add multiply is compiled in when ALU_MUL_EN is defined.
module alu_nbit_seq #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CW     = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    MUL  = 2'd2,
`endif
    HOLD = 2'd1
  } state_t;

  state_t state_q, state_d;
  logic   in_ready;
  logic   load_alu;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

`ifdef ALU_MUL_EN
  logic               start_mul;
  logic               load_mul;
  logic               op_is_mul;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt_q;

  assign op_is_mul = (Op == OP_MUL);
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Subtract is formed as A + ~B + 1 so the carry out doubles as "no borrow".
  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
  assign sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (Op)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOR: alu_res = ~(A | B);
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = add_ovf;
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = sub_ovf;
      end
      OP_SLT: begin
        alu_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
        alu_c   = sub_full[WIDTH];
      end
`ifdef ALU_MUL_EN
      OP_MUL: alu_ill = 1'b0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    load_alu  = 1'b0;
`ifdef ALU_MUL_EN
    start_mul = 1'b0;
    load_mul  = 1'b0;
`endif
    case (state_q)
      IDLE: in_ready = 1'b1;
      HOLD: begin
        in_ready = OutReady;
        if (OutReady) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (cnt_q == '0) begin
          load_mul = 1'b1;
          state_d  = HOLD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // A new request in HOLD overrides the return to IDLE (back-to-back accept).
    if (InValid && in_ready) begin
`ifdef ALU_MUL_EN
      if (op_is_mul) begin
        start_mul = 1'b1;
        state_d   = MUL;
      end else begin
`else
      begin
`endif
        load_alu = 1'b1;
        state_d  = HOLD;
      end
    end
  end

  assign InReady  = in_ready;
  assign OutValid = (state_q == HOLD);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Result   <= '0;
      Zero     <= 1'b1;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
    end else if (load_alu) begin
      Result   <= alu_res;
      Zero     <= (alu_res == '0);
      CarryOut <= alu_c;
      Overflow <= alu_v;
      Illegal  <= alu_ill;
    end
`ifdef ALU_MUL_EN
    else if (load_mul) begin
      Result   <= acc_next[WIDTH-1:0];
      Zero     <= (acc_next[WIDTH-1:0] == '0);
      CarryOut <= 1'b0;
      Overflow <= |acc_next[2*WIDTH-1:WIDTH];
      Illegal  <= 1'b0;
    end
`endif
  end

`ifdef ALU_MUL_EN
  // One shift-add step per cycle; the step taken with cnt_q == 0 is the last.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, A};
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH - 1);
    end else if (state_q == MUL) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
`endif

endmodule
